dwt53_predict: RTL

// - Streaming predict (high-pass) lifting step of the reversible 5/3 DWT, one image line at a time.
// - Input: one (even, odd) sample pair per beat. Output: (even passthrough, high-pass detail) per beat.
// - Sits directly upstream of the update step. Downstream ShiftReg delay lines realign the low path.
// - Symmetric extension at line end. Full valid/ready flow control on both sides.

---
 rtl/dwt53_predict.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dwt53_predict.sv
// Streaming predict step of the reversible 5/3 DWT: (even, odd) pairs in, (even, detail) beats out.
// Optional line-length checker enabled by defining DWT53_PREDICT_LEN_CHECK_EN.
module dwt53_predict #(
    parameter int Width     = 16,
    parameter int LinePairs = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [Width-1:0] s_even_i,
    input  logic [Width-1:0] s_odd_i,
    input  logic             s_last_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [Width-1:0] m_low_o,
    output logic [Width:0]   m_high_o,
    output logic             m_last_o,
    output logic             err_o
);
    localparam int CntWidth = $clog2(LinePairs + 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HELD  = 2'd1,
        LAST  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [Width-1:0]   even_q, even_d;
    logic [Width-1:0]   odd_q, odd_d;
    logic               m_valid_q, m_valid_d;
    logic [Width-1:0]   m_low_q, m_low_d;
    logic [Width:0]     m_high_q, m_high_d;
    logic               m_last_q, m_last_d;
    logic               s_ready_c;
    logic               ld_ok;

    // d = o - floor((e0 + e1) / 2), evaluated in Width+1 bits so it never overflows.
    function automatic logic [Width:0] predict(input logic [Width-1:0] e0,
                                               input logic [Width-1:0] e1,
                                               input logic [Width-1:0] o);
        logic signed [Width:0] sum;
        sum = $signed({e0[Width-1], e0}) + $signed({e1[Width-1], e1});
        return $signed({o[Width-1], o}) - (sum >>> 1);
    endfunction

    assign ld_ok = !m_valid_q || m_ready_i;

    always_comb begin
        state_d   = state_q;
        even_d    = even_q;
        odd_d     = odd_q;
        m_valid_d = m_valid_q;
        m_low_d   = m_low_q;
        m_high_d  = m_high_q;
        m_last_d  = m_last_q;
        s_ready_c = 1'b0;
        if (ld_ok) begin
            m_valid_d = 1'b0;
        end
        case (state_q)
            EMPTY: begin
                s_ready_c = 1'b1;
                if (s_valid_i) begin
                    even_d  = s_even_i;
                    odd_d   = s_odd_i;
                    state_d = s_last_i ? LAST : HELD;
                end
            end
            HELD: begin
                s_ready_c = ld_ok;
                if (s_valid_i && ld_ok) begin
                    m_valid_d = 1'b1;
                    m_low_d   = even_q;
                    m_high_d  = predict(even_q, s_even_i, odd_q);
                    m_last_d  = 1'b0;
                    even_d    = s_even_i;
                    odd_d     = s_odd_i;
                    state_d   = s_last_i ? LAST : HELD;
                end
            end
            LAST: begin
                // Symmetric extension: the missing right neighbour mirrors e_k.
                if (ld_ok) begin
                    m_valid_d = 1'b1;
                    m_low_d   = even_q;
                    m_high_d  = predict(even_q, even_q, odd_q);
                    m_last_d  = 1'b1;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= EMPTY;
            even_q    <= '0;
            odd_q     <= '0;
            m_valid_q <= 1'b0;
            m_low_q   <= '0;
            m_high_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            even_q    <= even_d;
            odd_q     <= odd_d;
            m_valid_q <= m_valid_d;
            m_low_q   <= m_low_d;
            m_high_q  <= m_high_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_ready_o = s_ready_c;
    assign m_valid_o = m_valid_q;
    assign m_low_o   = m_low_q;
    assign m_high_o  = m_high_q;
    assign m_last_o  = m_last_q;

`ifdef DWT53_PREDICT_LEN_CHECK_EN
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept = s_valid_i && s_ready_c;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            if (s_last_i) begin
                cnt_d = '0;
                if (({1'b0, cnt_q} + (CntWidth + 1)'(1)) != (CntWidth + 1)'(LinePairs)) begin
                    err_d = 1'b1;
                end
            end else if (cnt_q != {CntWidth{1'b1}}) begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
